// File: rtl/fixed_point_pkg.sv
// Shared Q4.4 fixed-point definitions for the datapath library.
// Operand type, default split point and a real-valued view helper.
package fixed_point_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int FRAC_DEF  = 4;

  typedef logic [7:0] q4_4_t;

  function automatic real to_real(input q4_4_t v);
    return real'(v) / 16.0;
  endfunction

endpackage

// File: rtl/fp_sub_stage.sv
// Registered subtract slice: d = a - b - bin with borrow-out.
// Loads on en; holds otherwise, so a stalled stage keeps its contents.
module fp_sub_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         valid
);

  logic [W:0] full;

  // Extra top bit of the widened difference is the borrow-out
  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d     <= '0;
      bout  <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      d     <= full[W-1:0];
      bout  <= full[W];
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/unsigned_pipelined_fixed_point_subtractor.sv
// Two-stage unsigned Q4.4 subtractor with valid/ready on both sides.
// Low slice first, high slice consumes its registered borrow.
module unsigned_pipelined_fixed_point_subtractor
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int HI = WIDTH - FRAC;

  logic            adv1;
  logic            adv2;
  logic            s1_valid;
  logic [FRAC-1:0] lo_d1;
  logic [FRAC-1:0] lo_d2;
  logic            lo_b1;
  logic [HI-1:0]   a_hi1;
  logic [HI-1:0]   b_hi1;
  logic [HI-1:0]   hi_d2;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  fp_sub_stage #(.W(FRAC)) u_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv1),
    .valid_in (in_valid),
    .a        (A[FRAC-1:0]),
    .b        (B[FRAC-1:0]),
    .bin      (1'b0),
    .d        (lo_d1),
    .bout     (lo_b1),
    .valid    (s1_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hi1 <= '0;
      b_hi1 <= '0;
    end else if (adv1) begin
      a_hi1 <= A[WIDTH-1:FRAC];
      b_hi1 <= B[WIDTH-1:FRAC];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_d2 <= '0;
    end else if (adv2) begin
      lo_d2 <= lo_d1;
    end
  end

  fp_sub_stage #(.W(HI)) u_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (adv2),
    .valid_in (s1_valid),
    .a        (a_hi1),
    .b        (b_hi1),
    .bin      (lo_b1),
    .d        (hi_d2),
    .bout     (Borrow),
    .valid    (out_valid)
  );

  // Clamp sits after the register, so it holds with the stalled result
  assign Diff = (SATURATE && Borrow) ? '0 : {hi_d2, lo_d2};

endmodule

// File: tb/tb_unsigned_pipelined_fixed_point_subtractor.sv
// Directed bench: saturating and wrapping instances share stimulus.
// Expected values are hand-computed Q4.4 differences.
module tb_unsigned_pipelined_fixed_point_subtractor;
  import fixed_point_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  out_ready;
  q4_4_t A;
  q4_4_t B;
  logic  in_ready_s, in_ready_w;
  logic  out_valid_s, out_valid_w;
  q4_4_t diff_s, diff_w;
  logic  borrow_s, borrow_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unsigned_pipelined_fixed_point_subtractor #(
    .WIDTH(8), .FRAC(4), .SATURATE(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .out_valid(out_valid_s), .out_ready(out_ready),
    .Diff(diff_s), .Borrow(borrow_s)
  );

  unsigned_pipelined_fixed_point_subtractor #(
    .WIDTH(8), .FRAC(4), .SATURATE(1'b0)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .out_valid(out_valid_w), .out_ready(out_ready),
    .Diff(diff_w), .Borrow(borrow_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input q4_4_t ds,
                         input q4_4_t dw, input logic b);
    chk({tag, ".valid_s"}, 32'(out_valid_s), 32'(v));
    chk({tag, ".valid_w"}, 32'(out_valid_w), 32'(v));
    chk({tag, ".diff_s"}, 32'(diff_s), 32'(ds));
    chk({tag, ".diff_w"}, 32'(diff_w), 32'(dw));
    chk({tag, ".borrow_s"}, 32'(borrow_s), 32'(b));
    chk({tag, ".borrow_w"}, 32'(borrow_w), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input q4_4_t a, input q4_4_t b,
                          input q4_4_t ds, input q4_4_t dw, input logic bw);
    tick();
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready_s), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".mid"}, 32'(out_valid_s), 32'd0);
    tick();
    chk_out(tag, 1'b1, ds, dw, bw);
  endtask

  q4_4_t sa [8] = '{8'h50, 8'h11, 8'h80, 8'hFF, 8'h0F, 8'hA5, 8'h3C, 8'h01};
  q4_4_t sb [8] = '{8'h20, 8'h01, 8'h7F, 8'hFF, 8'h10, 8'h5A, 8'h0C, 8'h00};
  q4_4_t sds[8] = '{8'h30, 8'h10, 8'h01, 8'h00, 8'h00, 8'h4B, 8'h30, 8'h01};
  q4_4_t sdw[8] = '{8'h30, 8'h10, 8'h01, 8'h00, 8'hFF, 8'h4B, 8'h30, 8'h01};
  logic  sbw[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0;
    #12;
    chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("reset.in_ready", 32'(in_ready_s), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send_one("t1", 8'h1E, 8'h0F, 8'h0F, 8'h0F, 1'b0);
    send_one("t2", 8'h20, 8'h01, 8'h1F, 8'h1F, 1'b0);
    send_one("t3", 8'h10, 8'hF0, 8'h00, 8'h20, 1'b1);
    send_one("aeqb", 8'h44, 8'h44, 8'h00, 8'h00, 1'b0);

    // Stream with a three-cycle output stall
    tick();
    out_ready = 1'b0; in_valid = 1'b1; A = 8'h30; B = 8'h18;
    tick();
    chk("t4.rdy1", 32'(in_ready_s), 32'd1);
    A = 8'hFF; B = 8'h00;
    tick();
    chk("t4.rdy_full", 32'(in_ready_s), 32'd0);
    chk_out("t4.p0", 1'b1, 8'h18, 8'h18, 1'b0);
    A = 8'h44; B = 8'h44;
    tick();
    chk("t4.rdy_hold", 32'(in_ready_s), 32'd0);
    chk_out("t4.hold1", 1'b1, 8'h18, 8'h18, 1'b0);
    tick();
    chk_out("t4.hold2", 1'b1, 8'h18, 8'h18, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t4.rdy_release", 32'(in_ready_s), 32'd1);
    tick();
    chk_out("t4.p1", 1'b1, 8'hFF, 8'hFF, 1'b0);
    A = 8'h00; B = 8'h01;
    tick();
    chk_out("t4.p2", 1'b1, 8'h00, 8'h00, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("t4.p3", 1'b1, 8'h00, 8'hFF, 1'b1);
    tick();
    chk("t4.drain", 32'(out_valid_s), 32'd0);

    // Back-to-back stream at full throughput
    A = sa[0]; B = sb[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i >= 1)
        chk_out($sformatf("t5.r%0d", i - 1), 1'b1, sds[i-1], sdw[i-1],
                sbw[i-1]);
      if (i < 7) begin
        chk($sformatf("t5.rdy%0d", i), 32'(in_ready_s), 32'd1);
        A = sa[i+1]; B = sb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    chk("t5.drain", 32'(out_valid_s), 32'd0);

    // Asynchronous reset with both stages occupied
    out_ready = 1'b0; in_valid = 1'b1; A = 8'h77; B = 8'h11;
    tick();
    A = 8'h66;
    tick();
    in_valid = 1'b0;
    chk("t6.full", 32'(in_ready_s), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("t6.rst_rdy", 32'(in_ready_s), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_one("t6.after", 8'h2A, 8'h15, 8'h15, 8'h15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unsigned_pipelined_fixed_point_subtractor.md
Name: unsigned_pipelined_fixed_point_subtractor

Overview:
Two-stage pipelined unsigned Q4.4 fixed-point subtractor (Diff = A - B). It complements the unsigned pipelined fixed-point adder in the datapath library and uses the same Q4.4 operand format. Unlike the adder, it has a valid/ready handshake on both sides and an explicit borrow/underflow flag, so it can sit between streaming stages that apply backpressure.

Parameters:
WIDTH, 8, total operand width in bits
FRAC, 4, fractional bits (Q(WIDTH-FRAC).FRAC); the stage-1/stage-2 split point
SATURATE, 1, 1 = clamp result to 0 on underflow; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
A  input  WIDTH  minuend, unsigned Q4.4
B  input  WIDTH  subtrahend, unsigned Q4.4
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
Diff  output  WIDTH  difference, unsigned Q4.4
Borrow  output  1  1 when A < B (underflow), qualified by out_valid

Behaviour:
- Reset: async assert on rst_n low. All pipeline registers clear. out_valid=0, Diff=0, Borrow=0, in_ready=1 after deassert. Deassertion is synchronous to clk at the design level.
- Accept: transfer when in_valid && in_ready on a rising clk edge.
- Stage 1: compute A[FRAC-1:0] - B[FRAC-1:0] with borrow-out. Register the low result, the borrow, A[WIDTH-1:FRAC], B[WIDTH-1:FRAC], and s1_valid.
- Stage 2: compute A_hi - B_hi - borrow_lo. The final borrow-out is Borrow. Register Diff, Borrow, and out_valid.
- Latency: out_valid rises exactly 2 cycles after the accept edge when there is no stall. Throughput is 1 result per cycle.
- Arithmetic rules:
  - A >= B: Diff = A - B, Borrow = 0.
  - A < B and SATURATE=1: Diff = 0, Borrow = 1.
  - A < B and SATURATE=0: Diff = (A - B) mod 2^WIDTH, Borrow = 1.
  - No rounding. Fraction bits are exact.
- Flow control:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational, no combinational path from in_valid)
- Stall: while out_valid && !out_ready, Diff, Borrow and out_valid hold stable. Stage 1 holds when it is full. With both stages full, in_ready=0 and no data is lost or duplicated.
- Simultaneous events: in the same cycle, output consumed + stage 1 advancing + new accept are all legal. Ordering is strictly FIFO.
- Reset mid-operation: all in-flight data is discarded. Outputs go to their reset values immediately (asynchronously).
- A=B: Diff=0, Borrow=0.
- Boundary cases: B=0 gives Diff=A. A=0xFF, B=0x00 gives 0xFF.

Decomposition:
- Shared package fixed_point_pkg holds:
  - WIDTH/FRAC defaults
  - typedef q4_4_t (logic [7:0])
  - a to-real conversion helper (value/16.0) used by benches
- One natural sub-module: fp_sub_stage, a registered nibble-subtract slice with valid/hold. It is instantiated twice: low slice with borrow-in tied 0, high slice fed by the registered borrow. The saturate mux and flow control stay in the top level.

Test Plan:
1. A=0x1E (1.875), B=0x0F (0.9375), out_ready=1 -> Diff=0x0F (0.9375), Borrow=0, out_valid high 2 cycles after accept.
2. A=0x20 (2.0), B=0x01 (0.0625) (low-nibble borrow propagates) -> Diff=0x1F (1.9375), Borrow=0.
3. A=0x10 (1.0), B=0xF0 (15.0) -> SATURATE=1: Diff=0x00, Borrow=1; SATURATE=0: Diff=0x20, Borrow=1.
4. Stream of 4 pairs (0x30-0x18, 0xFF-0x00, 0x44-0x44, 0x00-0x01) with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts. Held outputs stay stable. Results 0x18, 0xFF, 0x00, 0x00/Borrow=1 (SATURATE=1) appear in order with no loss.
5. Continuous in_valid and out_ready=1 for 8 pairs -> 8 results on 8 consecutive cycles starting 2 cycles after the first accept.
6. rst_n pulled low while both stages are valid -> out_valid=0, Diff=0, Borrow=0 without waiting for a clock. After release, in_ready=1 and the next pair yields the correct result 2 cycles later.
